demux_dispatch_ctrl: RTL and testbench

Sequencing controller for the 16-bit 1-to-4 data demultiplexer. It accepts words on a valid/ready input and holds each word in a one-entry buffer. It picks a destination channel, either by round-robin or from an address supplied with the word, and drives the demux data, select and active-low enable until that channel accepts the word. It sits between a single upstream producer and four downstream consumers, with the demux instance between this block and the consumers.

---
 rtl/demux_dispatch_ctrl_pkg.sv | 27 ++
 rtl/demux_dispatch_ctrl_rr_pick.sv | 26 ++
 rtl/demux_dispatch_ctrl.sv | 104 ++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared types and helpers for the demux dispatch controller.
// Holds channel/data widths, the FSM state type and the channel-to-select wiring map.
package demux_dispatch_ctrl_pkg;

  localparam int NCH = 4;
  localparam int DW  = 16;

  typedef logic [1:0] ch_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // The demux select lines are wired one position ahead of the channel index.
  function automatic logic [1:0] ch_to_sel(input ch_t c);
    return c + 2'd1;
  endfunction

  function automatic logic [NCH-1:0] ch_onehot(input ch_t c);
    logic [NCH-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_rr_pick.sv
// Combinational round-robin picker: first ready channel scanning upward from rr_ptr.
// Falls back to rr_ptr itself when nothing is ready.
module demux_dispatch_ctrl_rr_pick
  import demux_dispatch_ctrl_pkg::*;
(
  input  ch_t            rr_ptr,
  input  logic [NCH-1:0] ready,
  output ch_t            pick,
  output logic           any_ready
);

  ch_t idx;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    pick      = rr_ptr;
    any_ready = |ready;
    idx       = rr_ptr;
    // Scan from farthest to nearest so the nearest ready channel wins.
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = rr_ptr + ch_t'(i);
      if (ready[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Sequencing controller for a 16-bit 1-to-4 demux: one-entry buffer, round-robin or
// addressed destination, holds data/select/enable until the chosen channel accepts.
module demux_dispatch_ctrl
  import demux_dispatch_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_data,
  input  logic [1:0]     in_dest,
  output logic           in_ready,
  input  logic [NCH-1:0] out_ready,
  output logic [NCH-1:0] out_valid,
  output logic [DW-1:0]  dmx_data,
  output logic [1:0]     dmx_sel,
  output logic           dmx_el,
  output logic           busy,
  output logic [15:0]    tx_count
);

  state_t        state_q, state_d;
  logic [DW-1:0] data_q;
  ch_t           dest_q, dest_d;
  logic          mode_q;
  ch_t           rr_ptr_q;
  logic [15:0]   tx_count_q;

  logic          capture, deliver;
  ch_t           rr_pick_idx;
  logic          rr_any;

  demux_dispatch_ctrl_rr_pick u_rr_pick (
    .rr_ptr    (rr_ptr_q),
    .ready     (out_ready),
    .pick      (rr_pick_idx),
    .any_ready (rr_any)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    deliver = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Only the latched destination's ready matters; dest is never re-targeted.
        if (out_ready[dest_q]) begin
          deliver = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (mode)        dest_d = in_dest;
    else if (rr_any) dest_d = rr_pick_idx;
    else             dest_d = rr_ptr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the data buffer is reset too, because dmx_data has a defined value out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      dest_q     <= '0;
      mode_q     <= 1'b0;
      rr_ptr_q   <= '0;
      tx_count_q <= '0;
    end else begin
      if (capture) begin
        data_q <= in_data;
        dest_q <= dest_d;
        mode_q <= mode;
      end
      if (deliver) begin
        tx_count_q <= tx_count_q + 16'd1;
        if (!mode_q) rr_ptr_q <= dest_q + 2'd1;
      end
    end
  end

  // All handshake and demux controls decode from registered state only.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == HOLD);
  assign dmx_el    = (state_q != HOLD);
  assign dmx_sel   = (state_q == HOLD) ? ch_to_sel(dest_q) : 2'b00;
  assign out_valid = (state_q == HOLD) ? ch_onehot(dest_q) : '0;
  assign dmx_data  = data_q;
  assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: vector table plus hand-written corner sequences,
// with a scoreboard queue checked whenever a channel accepts the offered word.
module tb_demux_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  in_dest = '0;
  logic        in_ready;
  logic [3:0]  out_ready = '0;
  logic [3:0]  out_valid;
  logic [15:0] dmx_data;
  logic [1:0]  dmx_sel;
  logic        dmx_el;
  logic        busy;
  logic [15:0] tx_count;

  demux_dispatch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .dmx_data  (dmx_data),
    .dmx_sel   (dmx_sel),
    .dmx_el    (dmx_el),
    .busy      (busy),
    .tx_count  (tx_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          ch;
    logic [15:0] data;
  } sb_item_t;

  typedef struct {
    logic        mode;
    logic [1:0]  dest;
    logic [15:0] data;
    logic [3:0]  rdy;
    int          ch;
    logic [1:0]  sel;
  } vec_t;

  sb_item_t    sb[$];
  logic [15:0] exp_tx = '0;
  vec_t        vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: an accepted offer is visible before the edge that completes it.
  always @(negedge clk) begin
    int       ch;
    sb_item_t e;
    if (!rst && ((out_valid & out_ready) != 4'b0000)) begin
      ch = -1;
      for (int c = 0; c < 4; c++) if (out_valid[c]) ch = c;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got ch %0d data 0x%0h expected none", ch, dmx_data);
      end else begin
        e = sb.pop_front();
        check("deliver_ch", ch, e.ch);
        check("deliver_data", dmx_data, e.data);
        exp_tx++;
      end
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    out_ready = 4'b0000;
    step();
    step();
    rst = 1'b0;
    sb.delete();
    exp_tx = '0;
  endtask

  task automatic send(input vec_t v);
    int guard;
    out_ready = v.rdy;
    mode      = v.mode;
    in_dest   = v.dest;
    in_data   = v.data;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    check("send_in_ready", in_ready, 1'b1);
    sb.push_back('{ch: v.ch, data: v.data});
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    // One cycle after capture the word must be on offer.
    check("offer_valid", out_valid, 4'b0001 << v.ch);
    check("offer_sel", dmx_sel, v.sel);
    check("offer_el", dmx_el, 1'b0);
    check("offer_data", dmx_data, v.data);
    check("offer_in_ready", in_ready, 1'b0);
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL delivery_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    check("post_in_ready", in_ready, 1'b1);
    check("post_el", dmx_el, 1'b1);
    check("post_valid", out_valid, 4'b0000);
    check("post_tx_count", tx_count, exp_tx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           mode  dest   data      rdy      ch sel
    vecs[0]  = '{1'b0, 2'd0, 16'h1111, 4'b1111, 0, 2'b01};
    vecs[1]  = '{1'b0, 2'd0, 16'h2222, 4'b1111, 1, 2'b10};
    vecs[2]  = '{1'b0, 2'd0, 16'h3333, 4'b1111, 2, 2'b11};
    vecs[3]  = '{1'b0, 2'd0, 16'h4444, 4'b1111, 3, 2'b00};
    vecs[4]  = '{1'b0, 2'd0, 16'h5555, 4'b1111, 0, 2'b01};
    vecs[5]  = '{1'b1, 2'd3, 16'hBEEF, 4'b1000, 3, 2'b00};
    vecs[6]  = '{1'b0, 2'd0, 16'h0C0C, 4'b0100, 2, 2'b11};
    vecs[7]  = '{1'b0, 2'd0, 16'h0D0D, 4'b1111, 3, 2'b00};
    vecs[8]  = '{1'b0, 2'd3, 16'h0E0E, 4'b0010, 1, 2'b10};
    vecs[9]  = '{1'b0, 2'd0, 16'h0F0F, 4'b0001, 0, 2'b01};
    vecs[10] = '{1'b1, 2'd1, 16'h1010, 4'b1110, 1, 2'b10};
    vecs[11] = '{1'b0, 2'd0, 16'h1212, 4'b1111, 1, 2'b10};

    do_reset();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_valid", out_valid, 4'b0000);
    check("rst_el", dmx_el, 1'b1);
    check("rst_sel", dmx_sel, 2'b00);
    check("rst_data", dmx_data, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_count", tx_count, 16'h0000);

    for (int i = 0; i < 12; i++) begin
      send(vecs[i]);
      if (i == 4) check("five_words_tx", tx_count, 16'd5);
    end

    // Round-robin with nothing ready: pointer is now 2, so dest falls back to 2.
    mode = 1'b0; out_ready = 4'b0000; in_data = 16'h2020;
    sb.push_back('{ch: 2, data: 16'h2020});
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("noready_valid", out_valid, 4'b0100);
    check("noready_sel", dmx_sel, 2'b11);
    out_ready = 4'b0010;
    step();
    check("noready_still_busy", busy, 1'b1);
    out_ready = 4'b0100;
    step();
    check("noready_done", sb.size(), 0);
    check("noready_tx", tx_count, exp_tx);

    // Stall: addressed word held through ten not-ready cycles, mode flips mid-hold.
    do_reset();
    mode = 1'b1; in_dest = 2'd0; in_data = 16'hA5A5; out_ready = 4'b0000;
    sb.push_back('{ch: 0, data: 16'hA5A5});
    in_valid = 1'b1;
    step();
    in_data = 16'h1234;
    mode    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      out_ready = (i < 5) ? 4'b0000 : 4'b1110;
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_data", dmx_data, 16'hA5A5);
      check("stall_sel", dmx_sel, 2'b01);
      check("stall_el", dmx_el, 1'b0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 4'b0001;
    step();
    check("stall_drained", sb.size(), 0);
    check("stall_tx", tx_count, 16'd1);
    check("stall_in_ready_back", in_ready, 1'b1);

    // Reset while holding: the word must vanish and counters clear.
    mode = 1'b1; in_dest = 2'd2; in_data = 16'h7777; out_ready = 4'b0000;
    in_valid = 1'b1;
    step();
    check("midhold_busy", busy, 1'b1);
    rst = 1'b1;
    in_data = 16'h8888;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    exp_tx = '0;
    check("midhold_el", dmx_el, 1'b1);
    check("midhold_valid", out_valid, 4'b0000);
    check("midhold_in_ready", in_ready, 1'b1);
    check("midhold_tx", tx_count, 16'h0000);
    check("midhold_busy_clr", busy, 1'b0);
    out_ready = 4'b1111;
    repeat (3) step();
    send('{1'b0, 2'd0, 16'h3C3C, 4'b1111, 0, 2'b01});

    // Counter wrap from a forced 0xFFFF.
    @(negedge clk);
    force dut.tx_count_q = 16'hFFFF;
    step();
    @(negedge clk);
    release dut.tx_count_q;
    exp_tx = 16'hFFFF;
    check("wrap_preload", tx_count, 16'hFFFF);
    send('{1'b0, 2'd0, 16'h4B4B, 4'b1111, 1, 2'b10});
    check("wrap_zero", tx_count, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
